ledwalker_n: RTL and testbench
==============================

Name: ledwalker_n

Overview:
- Parametrised successor to the fixed 8-LED walker.
- Walks a single lit LED across NLEDS outputs at a programmable step rate.
- Runtime mode select: bounce (back-and-forth) or wrap (circular).
- Provides run enable, a step strobe and the current position for debug/LA capture.
- Sits directly between the board clock and the LED pins.

Parameters:
- NLEDS, 8, number of LEDs (legal range 1..64).
- DW, 24, width of the step divider counter and i_div.
- PW, $clog2(NLEDS) (minimum 1), width of o_pos.

Ports:
- i_clk  input  1  system clock.
- i_reset  input  1  asynchronous, active-high reset.
- i_en  input  1  run enable; when low, all state holds.
- i_mode  input  1  0 = bounce, 1 = wrap.
- i_div  input  DW  step interval minus one (cycles between steps = i_div+1).
- o_led  output  NLEDS  LED drive, one-hot.
- o_pos  output  PW  index of the lit LED.
- o_step  output  1  single-cycle pulse, high on the cycle o_pos/o_led take a new value.

Behaviour:
- Reset is asynchronous and active-high. Reset values:
  - o_pos = 0, o_led = 1 (bit 0 lit), o_step = 0.
  - Direction register = UP.
  - Divider counter = 0.
- Divider (i_en high):
  - Counter == 0: assert step and reload counter with i_div.
  - Otherwise: decrement counter.
  - With i_en low: counter, position and direction hold; o_step = 0.
- Step rate:
  - First step occurs on the first enabled clock after reset.
  - Subsequent steps follow every i_div+1 enabled cycles.
  - i_div = 0 steps every cycle.
- i_div changes take effect at the next reload only; an in-flight count is not truncated.
- Direction FSM, 2 states: UP, DOWN. On each step:
  - Bounce, UP: pos < NLEDS-1 -> pos+1; pos == NLEDS-1 -> pos-1 and go DOWN.
  - Bounce, DOWN: pos > 0 -> pos-1; pos == 0 -> pos+1 and go UP.
  - Wrap: pos == NLEDS-1 -> 0, else pos+1. Direction forced to UP.
- Bounce sequence for NLEDS = 8: 0..7, 6..1, 0, repeating. Full period is 14 steps, each endpoint lit once per period.
- Mode change mid-walk:
  - Bounce -> wrap: continues upward from the current pos.
  - Wrap -> bounce: starts in UP from the current pos.
  - No position jump in either case.
- NLEDS = 1: pos stays 0 and o_led stays 1. o_step still pulses at the divider rate.
- NLEDS = 2: bounce and wrap produce the same sequence 0,1,0,1.
- Registering and latency:
  - o_led, o_pos and o_step are all registered.
  - o_led is always equal to 1 << o_pos in the same cycle.
  - Latency from divider expiry to the new o_led is 1 clock.
- Invariants (asserted under FORMAL):
  - o_led is always one-hot.
  - o_pos <= NLEDS-1.
  - Direction is UP whenever i_mode = 1.
- Reset asserted mid-step overrides everything and takes effect immediately (asynchronous).

Optional Feature:
- Macro: LEDWALKER_PWM_EN.
- Defined:
  - Adds input i_bright [3:0] and a free-running 4-bit PWM counter. The counter is reset to 0 and runs regardless of i_en.
  - The internal one-hot pattern is still held in a register.
  - o_led = pattern & {NLEDS{pwm_cnt < i_bright}}.
  - i_bright = 0 gives LEDs always off; i_bright = 15 gives 15/16 duty.
  - The one-hot invariant relaxes to "at most one bit set".
  - Position, direction and o_step behaviour are unchanged.
- Undefined: no i_bright port and no PWM counter; o_led is driven full-on as described above.

Test Plan:
- Reset release, NLEDS=8, i_mode=0, i_div=2, i_en=1 -> o_step every 3 clocks. o_pos sequence 1,2,...,7,6,...,0,1; o_led 8'h02 after the first step, 8'h80 at pos 7.
- Wrap mode, i_div=0, NLEDS=8 -> one step per clock, o_led 01,02,...,80,01. No 8'h40 after 8'h80.
- i_en dropped for 10 cycles at pos 5 (bounce, DOWN) -> o_pos holds 5, no o_step. On re-enable, the remaining divider count resumes, then pos goes to 4.
- At pos 6 in bounce DOWN, switch i_mode to 1 -> next step gives pos 7, then 0. Switch back to 0 at pos 2 -> 3, 4, ...
- Assert i_reset asynchronously between clock edges at pos 4 -> o_led reads 8'h01 and o_pos reads 0 before the next edge; on release the walk restarts UP from pos 0.
- With LEDWALKER_PWM_EN, i_bright=4, i_div large -> the lit bit is high exactly 4 of every 16 clocks. i_bright=0 -> o_led = 0 throughout, while o_pos still advances.

Source files
------------

// File: rtl/ledwalker_n.sv
// Single-LED walker over NLEDS outputs with programmable step interval and bounce/wrap modes.
// Optional PWM dimming is enabled by defining LEDWALKER_PWM_EN (adds i_bright).
module ledwalker_n #(
    parameter int NLEDS = 8,
    parameter int DW    = 24,
    parameter int PW    = (NLEDS > 1) ? $clog2(NLEDS) : 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic             i_mode,
    input  logic [DW-1:0]    i_div,
`ifdef LEDWALKER_PWM_EN
    input  logic [3:0]       i_bright,
`endif
    output logic [NLEDS-1:0] o_led,
    output logic [PW-1:0]    o_pos,
    output logic             o_step
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [PW-1:0] LAST = PW'(NLEDS - 1);

    logic [DW-1:0]    r_cnt;
    logic [PW-1:0]    r_pos;
    logic [NLEDS-1:0] r_pattern;
    logic             r_step;
    dir_t             r_dir;

    dir_t             w_dir_nxt;
    logic [PW-1:0]    w_pos_nxt;
    logic             w_expire;

    assign w_expire = i_en && (r_cnt == '0);

    // Reload happens only on expiry, so a new i_div never cuts an in-flight count short.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (r_cnt == '0) begin
                r_cnt <= i_div;
            end else begin
                r_cnt <= r_cnt - DW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_dir     <= DIR_UP;
            r_pos     <= '0;
            r_pattern <= NLEDS'(1);
            r_step    <= 1'b0;
        end else begin
            r_dir     <= w_dir_nxt;
            r_pos     <= w_pos_nxt;
            r_pattern <= NLEDS'(1) << w_pos_nxt;
            r_step    <= w_expire;
        end
    end

    always_comb begin
        w_dir_nxt = r_dir;
        w_pos_nxt = r_pos;
        // Wrap mode pins direction to UP so a later switch to bounce starts upward.
        if (i_mode) begin
            w_dir_nxt = DIR_UP;
        end
        if (w_expire) begin
            if (NLEDS == 1) begin
                w_pos_nxt = '0;
            end else if (i_mode) begin
                w_pos_nxt = (r_pos == LAST) ? '0 : r_pos + PW'(1);
            end else begin
                case (r_dir)
                    DIR_UP: begin
                        if (r_pos < LAST) begin
                            w_pos_nxt = r_pos + PW'(1);
                        end else begin
                            w_pos_nxt = r_pos - PW'(1);
                            w_dir_nxt = DIR_DOWN;
                        end
                    end
                    DIR_DOWN: begin
                        if (r_pos > '0) begin
                            w_pos_nxt = r_pos - PW'(1);
                        end else begin
                            w_pos_nxt = r_pos + PW'(1);
                            w_dir_nxt = DIR_UP;
                        end
                    end
                    default: begin
                        w_pos_nxt = r_pos;
                        w_dir_nxt = DIR_UP;
                    end
                endcase
            end
        end
    end

`ifdef LEDWALKER_PWM_EN
    logic [3:0] r_pwm;
    logic       w_pwm_on;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pwm <= '0;
        end else begin
            r_pwm <= r_pwm + 4'd1;
        end
    end

    assign w_pwm_on = (r_pwm < i_bright);
    assign o_led    = r_pattern & {NLEDS{w_pwm_on}};
`else
    assign o_led    = r_pattern;
`endif

    assign o_pos  = r_pos;
    assign o_step = r_step;

`ifdef FORMAL
    always_comb begin
        if (!i_reset) begin
`ifdef LEDWALKER_PWM_EN
            assert ($onehot0(o_led));
`else
            assert ($onehot(o_led));
`endif
            assert (r_pos <= LAST);
        end
    end

    property p_dir_up_in_wrap;
        @(posedge i_clk) disable iff (i_reset) $past(i_mode) |-> (r_dir == DIR_UP);
    endproperty
    a_dir_up_in_wrap: assert property (p_dir_up_in_wrap);
`endif

endmodule

// File: tb/tb_ledwalker_n.sv
// Bench for ledwalker_n: directed scenarios plus randomized enable/mode/divider traffic,
// checked every cycle against a position/direction/countdown reference model.
module tb_ledwalker_n;

    localparam int N  = 8;
    localparam int DW = 24;
    localparam int PW = 3;

    logic          clk;
    logic          reset;
    logic          en;
    logic          mode;
    logic [DW-1:0] div;
    logic [N-1:0]  o_led;
    logic [PW-1:0] o_pos;
    logic          o_step;
`ifdef LEDWALKER_PWM_EN
    logic [3:0]    bright;
`endif

    ledwalker_n #(
        .NLEDS (N),
        .DW    (DW),
        .PW    (PW)
    ) dut (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_en     (en),
        .i_mode   (mode),
        .i_div    (div),
`ifdef LEDWALKER_PWM_EN
        .i_bright (bright),
`endif
        .o_led    (o_led),
        .o_pos    (o_pos),
        .o_step   (o_step)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: position, direction as +1/-1, cycles left before next step.
    int m_pos;
    int m_dir;
    int m_rem;
    int m_pwm;
    bit m_step;

    task automatic model_reset();
        m_pos  = 0;
        m_dir  = 1;
        m_rem  = 0;
        m_pwm  = 0;
        m_step = 0;
    endtask

    task automatic model_advance();
        if (N == 1) begin
            m_pos = 0;
        end else if (mode) begin
            m_pos = (m_pos + 1) % N;
        end else begin
            if (m_pos + m_dir < 0 || m_pos + m_dir > N - 1) m_dir = -m_dir;
            m_pos = m_pos + m_dir;
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            model_reset();
        end else begin
            if (mode) m_dir = 1;
            m_step = 0;
            if (en) begin
                if (m_rem == 0) begin
                    m_step = 1;
                    m_rem  = int'(div);
                    model_advance();
                end else begin
                    m_rem = m_rem - 1;
                end
            end
            m_pwm = (m_pwm + 1) % 16;
        end
    endtask

    function automatic logic [N-1:0] exp_led();
        logic [N-1:0] e;
        e = '0;
        e[m_pos] = 1'b1;
`ifdef LEDWALKER_PWM_EN
        if (!(m_pwm < int'(bright))) e = '0;
`endif
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("pos",  64'(o_pos),  64'(m_pos));
        check("led",  64'(o_led),  64'(exp_led()));
        check("step", 64'(o_step), 64'(m_step));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        bit found;
        clk   = 1'b0;
        reset = 1'b1;
        en    = 1'b0;
        mode  = 1'b0;
        div   = '0;
`ifdef LEDWALKER_PWM_EN
        bright = 4'd15;
`endif
        model_reset();
        #3;
`ifdef LEDWALKER_PWM_EN
        check("rst_led", 64'(o_led), 64'(exp_led()));
`else
        check("rst_led", 64'(o_led), 64'h1);
`endif
        check("rst_pos",  64'(o_pos),  64'h0);
        check("rst_step", 64'(o_step), 64'h0);
        repeat (2) tick();

        // Bounce, step every 3 enabled cycles.
        reset = 1'b0;
        en    = 1'b1;
        div   = 24'd2;
        repeat (45) tick();

        // Wrap, one step per clock (new divider applies at next reload).
        mode = 1'b1;
        div  = '0;
        repeat (24) tick();

        // Enable drop mid-count at pos 5 heading down.
        mode = 1'b0;
        div  = 24'd2;
        for (int k = 0; k < 200 && !(m_pos == 5 && m_dir == -1); k++) tick();
        found = (m_pos == 5 && m_dir == -1);
        check("reach_pos5_down", 64'(found), 64'h1);
        tick();
        en = 1'b0;
        repeat (10) tick();
        en = 1'b1;
        repeat (12) tick();

        // Bounce->wrap at pos 6 going down, back to bounce at pos 2.
        for (int k = 0; k < 200 && !(m_pos == 6 && m_dir == -1 && m_step); k++) tick();
        found = (m_pos == 6 && m_dir == -1);
        check("reach_pos6_down", 64'(found), 64'h1);
        mode = 1'b1;
        for (int k = 0; k < 200 && !(m_pos == 2 && m_step); k++) tick();
        found = (m_pos == 2);
        check("reach_pos2_wrap", 64'(found), 64'h1);
        mode = 1'b0;
        repeat (15) tick();

        // Asynchronous reset between edges at pos 4.
        for (int k = 0; k < 200 && !(m_pos == 4); k++) tick();
        found = (m_pos == 4);
        check("reach_pos4", 64'(found), 64'h1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        tick();
        reset = 1'b0;
        repeat (20) tick();

`ifdef LEDWALKER_PWM_EN
        // Dimming: long divider so the lit bit stays put while the PWM cycles.
        bright = 4'd4;
        div    = 24'd1000;
        repeat (48) tick();
        bright = 4'd0;
        div    = '0;
        repeat (24) tick();
        bright = 4'd15;
`endif

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            en  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) mode = 1'($urandom_range(0, 1));
            div = DW'($urandom_range(0, 3));
`ifdef LEDWALKER_PWM_EN
            if ($urandom_range(0, 15) == 0) bright = 4'($urandom_range(0, 15));
`endif
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
